// File: rtl/msk_hpc3_pkg.sv
// Shared helpers for the HPC3 masked gadgets: randomness sizing, triangular
// randomness indexing and the lane/share bit layout.
package msk_hpc3_pkg;

  function automatic int rnd_lane(input int d);
    return d * (d - 1);
  endfunction

  // Position of pair (i,j), i<j, inside a packed upper-triangular matrix.
  function automatic int idx(input int i, input int j, input int d);
    return i * d - (i * (i + 1)) / 2 + (j - 1 - i);
  endfunction

  function automatic int pair_idx(input int i, input int j, input int d);
    return (i < j) ? idx(i, j, d) : idx(j, i, d);
  endfunction

  function automatic int sh(input int k, input int i, input int d);
    return k * d + i;
  endfunction

endpackage

// File: rtl/msk_hpc3_cells.sv
// Keep-boundary primitive cells so synthesis cannot merge logic across
// share domains.
module bin_AND (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = x & y;
endmodule

module bin_XOR (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = x ^ y;
endmodule

module bin_REG (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 1'b0;
    else        dout <= din;
  end
endmodule

// File: rtl/msk_hpc3_tof_lane.sv
// One bit lane of the HPC3 Toffoli/AND gadget: refreshes partial products into
// u/v/a registers on load, then compresses them into d output shares.
module msk_hpc3_tof_lane
  import msk_hpc3_pkg::*;
#(
  parameter  int d   = 2,
  parameter  int TOF = 1,
  localparam int NP  = d * (d - 1) / 2,
  localparam int NU  = d * (d - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [d-1:0]  a,
  input  logic [d-1:0]  b,
  input  logic [d-1:0]  c,
  input  logic [NP-1:0] mat0,
  input  logic [NP-1:0] mat1,
  output logic [d-1:0]  out
);

  logic [NU-1:0] u_in, u_d, u_q, v_in, v_d, v_q, prod;
  logic [d-1:0]  a_d, a_q;

  if (TOF == 0) begin : g_no_c
    logic unused_c;
    assign unused_c = ^c;
  end

  for (genvar i = 0; i < d; i++) begin : g_share
    assign a_d[i] = load ? a[i] : a_q[i];
    bin_REG a_reg (.clk(clk), .rst_n(rst_n), .din(a_d[i]), .dout(a_q[i]));

    for (genvar j2 = 0; j2 < d - 1; j2++) begin : g_pair
      localparam int J = (j2 < i) ? j2 : j2 + 1;
      localparam int R = pair_idx(i, J, d);
      localparam int N = i * (d - 1) + j2;
      logic b_sel, p, q;

      // The first pair of each share also carries the local a_i*b_i product.
      if (j2 == 0) begin : g_own
        bin_XOR x_rb (.x(mat0[R]), .y(b[i]), .z(b_sel));
      end else begin : g_cross
        assign b_sel = mat0[R];
      end
      bin_AND and_p (.x(a[i]), .y(b_sel), .z(p));
      bin_XOR x_q (.x(p), .y(mat1[R]), .z(q));

      if (j2 == 0 && TOF != 0) begin : g_tof
        bin_XOR x_c (.x(q), .y(c[i]), .z(u_in[N]));
      end else begin : g_plain
        assign u_in[N] = q;
      end

      assign u_d[N] = load ? u_in[N] : u_q[N];
      bin_REG u_reg (.clk(clk), .rst_n(rst_n), .din(u_d[N]), .dout(u_q[N]));

      bin_XOR x_v (.x(b[J]), .y(mat0[R]), .z(v_in[N]));
      assign v_d[N] = load ? v_in[N] : v_q[N];
      bin_REG v_reg (.clk(clk), .rst_n(rst_n), .din(v_d[N]), .dout(v_q[N]));

      bin_AND and_o (.x(a_q[i]), .y(v_q[N]), .z(prod[N]));
    end

    // Compression chain: all u terms first, then the registered a*v products.
    for (genvar t = 1; t < 2 * (d - 1); t++) begin : g_acc
      logic prev, term, sum;
      if (t == 1) begin : g_head
        assign prev = u_q[i*(d-1)];
      end else begin : g_link
        assign prev = g_acc[t-1].sum;
      end
      if (t < d - 1) begin : g_u
        assign term = u_q[i*(d-1)+t];
      end else begin : g_p
        assign term = prod[i*(d-1)+t-(d-1)];
      end
      bin_XOR x_acc (.x(prev), .y(term), .z(sum));
    end
    assign out[i] = g_acc[2*(d-1)-1].sum;
  end

endmodule

// File: rtl/msk_hpc3_tof_pipe.sv
// W-lane masked Toffoli (or plain AND when TOF=0) behind one ready/valid
// stage; randomness is consumed exactly once per accepted operand set.
module msk_hpc3_tof_pipe
  import msk_hpc3_pkg::*;
#(
  parameter int d        = 2,
  parameter int W        = 8,
  parameter int TOF      = 1,
  parameter int RND_LANE = rnd_lane(d)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W*d-1:0]        ina,
  input  logic [W*d-1:0]        inb,
  input  logic [W*d-1:0]        inc,
  input  logic [W*RND_LANE-1:0] rnd,
  output logic                  rnd_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W*d-1:0]        out
);

  localparam int NP = RND_LANE / 2;

  logic accept;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign rnd_ready = accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_valid <= 1'b0;
    else if (accept)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  for (genvar k = 0; k < W; k++) begin : g_lane
    msk_hpc3_tof_lane #(.d(d), .TOF(TOF)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept),
      .a    (ina[sh(k, 0, d) +: d]),
      .b    (inb[sh(k, 0, d) +: d]),
      .c    (inc[sh(k, 0, d) +: d]),
      .mat0 (rnd[k*RND_LANE +: NP]),
      .mat1 (rnd[k*RND_LANE+NP +: NP]),
      .out  (out[sh(k, 0, d) +: d])
    );
  end

endmodule

// File: tb/tb_msk_hpc3_tof_pipe.sv
// Randomised scoreboard bench for msk_hpc3_tof_pipe: unmasked reference values
// are queued on accept and compared against recombined output shares.
module tb_msk_hpc3_tof_pipe;

  localparam int D   = 3;
  localparam int W   = 8;
  localparam int RL  = D * (D - 1);
  localparam int AW  = W * D;
  localparam int RW  = W * RL;
  localparam int D2  = 2;
  localparam int W2  = 4;
  localparam int AW2 = W2 * D2;
  localparam int RW2 = W2 * D2 * (D2 - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic          in_valid, in_ready, rnd_ready, out_valid, out_ready;
  logic [AW-1:0] ina, inb, inc, out;
  logic [RW-1:0] rnd;

  logic           in_valid2, in_ready2, rnd_ready2, out_valid2, out_ready2;
  logic [AW2-1:0] ina2, inb2, inc2, out2;
  logic [RW2-1:0] rnd2;

  msk_hpc3_tof_pipe #(.d(D), .W(W), .TOF(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .inc(inc), .rnd(rnd), .rnd_ready(rnd_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  msk_hpc3_tof_pipe #(.d(D2), .W(W2), .TOF(0)) dut_and (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .ina(ina2), .inb(inb2), .inc(inc2), .rnd(rnd2), .rnd_ready(rnd_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out2)
  );

  int total = 0, bad = 0;
  int acc_cnt = 0, rnd_cnt = 0, got = 0, pushed = 0, dropped = 0;
  logic [W-1:0] exp_q[$];

  // Random sharing of a plain value: shares 1..dd-1 random, share 0 completes it.
  function automatic logic [63:0] mk_share(input logic [63:0] val, input int dd, input int ww);
    logic [63:0] v = '0;
    for (int k = 0; k < ww; k++) begin
      logic x = 1'b0;
      for (int i = 1; i < dd; i++) begin
        logic s = 1'($urandom_range(0, 1));
        v[k*dd+i] = s;
        x ^= s;
      end
      v[k*dd] = val[k] ^ x;
    end
    return v;
  endfunction

  function automatic logic [63:0] recomb(input logic [63:0] v, input int dd, input int ww);
    logic [63:0] r = '0;
    for (int k = 0; k < ww; k++)
      for (int i = 0; i < dd; i++) r[k] = r[k] ^ v[k*dd+i];
    return r;
  endfunction

  function automatic logic [W-1:0] rv();
    return W'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit ordy,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    @(negedge clk);
    #1;
    ina       = AW'(mk_share(64'(a), D, W));
    inb       = AW'(mk_share(64'(b), D, W));
    inc       = AW'(mk_share(64'(c), D, W));
    rnd       = RW'({$urandom, $urandom});
    in_valid  = v;
    out_ready = ordy;
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back((a & b) ^ c);
      pushed++;
    end
  endtask

  // Monitor: samples between the driver update and the next rising edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got %0h want none", recomb(64'(out), D, W));
        end else begin
          checkOutput("result", recomb(64'(out), D, W), 64'(exp_q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) acc_cnt++;
      if (rnd_ready) rnd_cnt++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      applyStimulus(1'b0, 1'b1, '0, '0, '0);
      n++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [AW-1:0]  snap;
    logic [W2-1:0]  a2, b2, c2, prev_exp2;

    in_valid = 1'b1; out_ready = 1'b0;
    ina = '1; inb = '1; inc = '1; rnd = '1;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    ina2 = '0; inb2 = '0; inc2 = '0; rnd2 = '0;
    prev_exp2 = '0;

    #5;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out", 64'(out), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_rnd_ready", 64'(rnd_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_hold_out", 64'(out), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_out", 64'(out), 64'd0);

    applyStimulus(1'b1, 1'b1, 8'h0B, 8'h06, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hF0, 8'hCC, 8'hAA);

    // Stall: accept one, then hold out_ready low while new operands churn.
    applyStimulus(1'b1, 1'b1, rv(), rv(), rv());
    applyStimulus(1'b1, 1'b0, rv(), rv(), rv());
    snap = out;
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) applyStimulus(1'b1, 1'b0, rv(), rv(), rv());
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_rnd_ready", 64'(rnd_ready), 64'd0);
      checkOutput("stall_out_stable", 64'(out), 64'(snap));
    end
    applyStimulus(1'b1, 1'b1, rv(), rv(), rv());
    checkOutput("drain_in_ready", 64'(in_ready), 64'd1);
    checkOutput("drain_rnd_ready", 64'(rnd_ready), 64'd1);

    for (int n = 0; n < 1000; n++)
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, rv(), rv(), rv());
    drain("drain_random");

    // Asynchronous reset while a result is stalled.
    applyStimulus(1'b1, 1'b1, 8'h5A, 8'h3C, 8'h81);
    applyStimulus(1'b0, 1'b0, rv(), rv(), rv());
    #2;
    checkOutput("held_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_out", 64'(out), 64'd0);
    dropped += exp_q.size();
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
    for (int n = 0; n < 20; n++) applyStimulus(1'b1, 1'b1, rv(), rv(), rv());
    drain("drain_post_reset");

    // Plain-AND instance: one-cycle latency, c ignored.
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      #1;
      if (n > 0) begin
        checkOutput("and_valid", 64'(out_valid2), 64'd1);
        checkOutput("and_result", recomb(64'(out2), D2, W2), 64'(prev_exp2));
        checkOutput("and_ready", 64'({in_ready2, rnd_ready2}), 64'd3);
      end
      if (n < 2) begin
        a2 = 4'b1011; b2 = 4'b0110; c2 = (n == 0) ? 4'b0001 : 4'b1110;
      end else begin
        a2 = W2'($urandom); b2 = W2'($urandom); c2 = W2'($urandom);
      end
      if (n == 13) in_valid2 = 1'b0;
      else         in_valid2 = 1'b1;
      ina2 = AW2'(mk_share(64'(a2), D2, W2));
      inb2 = AW2'(mk_share(64'(b2), D2, W2));
      inc2 = AW2'(mk_share(64'(c2), D2, W2));
      rnd2 = RW2'($urandom);
      prev_exp2 = a2 & b2;
      if (n == 1) checkOutput("and_basic", recomb(64'(out2), D2, W2), 64'h2);
    end

    checkOutput("rnd_count", 64'(rnd_cnt), 64'(acc_cnt));
    checkOutput("out_count", 64'(got), 64'(pushed - dropped));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_hpc3_tof_pipe.md
# msk_hpc3_tof_pipe

Multi-lane, flow-controlled masked Toffoli gadget that computes out = (a AND b) XOR c on W independent bit lanes of d-share Boolean sharings, using HPC3 refresh with one register stage. It wraps the per-lane masked computation in a ready/valid pipeline stage so that masked S-box datapaths can stall it without breaking share alignment or randomness freshness. In mode 0 the c operand is ignored and the block is a plain HPC3 AND.

## Interface
- d, 2: number of shares (d ≥ 2).
- W, 8: number of independent bit lanes.
- TOF, 1: 1 = XOR c into the product; 0 = c port ignored, plain AND.
- RND_LANE, d*(d-1): random bits per lane (two d(d-1)/2 matrices).

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  stage can accept this cycle.
- ina  in  W*d  sharing a; lane k share i at bit k*d+i.
- inb  in  W*d  sharing b; same layout.
- inc  in  W*d  sharing c; same layout; unused when TOF=0.
- rnd  in  W*RND_LANE  fresh randomness; lane k at bits [k*RND_LANE +: RND_LANE]; first half mat0, second half mat1.
- rnd_ready  out  1  high in the cycle rnd is consumed.
- out_valid  out  1  out holds a valid result.
- out_ready  in  1  downstream accepts out.
- out  out  W*d  sharing of (a&b)^c, same layout.

## Operation
- accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational from registers and out_ready only).
- rnd_ready = accept. Randomness presented in a non-accept cycle is not used; each accepted operand set uses rnd exactly once.
- Per lane k, per share pair (i,j), i≠j, j2 = index of j among shares ≠ i: r0 = mat0[i][j], r1 = mat1[i][j] (symmetric, diagonal 0).
  - u register: j2==0: a_i·(r0⊕b_i) ⊕ c_i ⊕ r1 (c_i term only when TOF=1); else a_i·r0 ⊕ r1.
  - v register: b_j ⊕ r0.
  - a register: a_i.
  - out_i = XOR over j2 of u[j2] ⊕ XOR over j2 of (a_reg_i · v[j2]).
- All u, v, a registers of all lanes load together, only on accept; otherwise hold. This keeps a_reg aligned with v under stall (the internal a register replaces an external delayed-a input).
- out_valid: set on accept, cleared when out_valid && out_ready && !accept; accept with simultaneous drain keeps it 1.
- Unmasked correctness: XOR of out shares of lane k = (a_k&b_k)^(TOF?c_k:0), for any rnd.
- Security: d-1 order probing, PINI, provided rnd is uniform and fresh per accept. Registers never load a partial product without its refresh randomness.

## Timing
- Reset (rst_n low, async): out_valid=0; all u, v, a registers=0, so out=0; in_ready=1, rnd_ready=in_valid.
- Latency: 1 cycle, accept at edge n → out_valid and result at n+1.
- Throughput: 1 result/cycle while out_ready=1.
- Stall: out_valid && !out_ready → in_ready=0, registers and out stable every cycle until drain.
- Reset mid-operation: held result discarded; first post-reset accept behaves as from cold.
- out is a function of registers only (no combinational path from ina/inb/inc/rnd to out); in_ready depends combinationally on out_ready.

## Structure
- Shared package msk_hpc3_pkg: RND_LANE function of d, triangular index function idx(i,j,d) = i*d − i(i+1)/2 + (j−1−i), share-layout index helper.
- Sub-module msk_hpc3_tof_lane: one lane, d shares, load-enable, TOF parameter; instantiated W times. Top holds the valid/ready control and the rnd slicing only.
- Use the codebase's bin_AND/bin_XOR/bin_REG cells inside the lane so synthesis does not merge share domains; enabled register is a bin_REG with mux on its input.

## Test plan
- Reset: assert rst_n=0 with in_valid=1 → out_valid=0, out=0, in_ready=1; release, no glitch on out.
- Basic d=2, W=4, TOF=1: a=1011, b=0110, c=0001 (random masks, random rnd), out_ready=1 → one cycle later out_valid=1, recombined out=0011.
- Mode TOF=0, same operands → recombined 0010; inc toggling has no effect.
- Stall: accept X, hold out_ready=0 for 5 cycles while in_valid=1 with changing ina/rnd → in_ready=0, rnd_ready=0, out shares bit-identical all 5 cycles; on out_ready=1, next operand accepted same cycle, result after one cycle.
- Back-to-back 1000 random vectors, d=3, W=8, random out_ready → every recombined output matches reference model in order, none lost or duplicated; rnd_ready count equals accepted count.
- Async reset asserted while out_valid=1 and stalled → out_valid and out drop to 0 immediately, without waiting for a clk edge.
